// File: rtl/alu_issue_stage.sv
// ID/EX register ahead of the ALU: resolves MEM/WB bypass and selects operands, 1-cycle latency.
// Entry holds while out_ready is low (in_ready drops); held register operands track WB writes.
module alu_issue_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [3:0]            in_alu_op,
    input  logic [1:0]            in_a_sel,
    input  logic [1:0]            in_b_sel,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_rd_we,
    input  logic                  fwd_mem_we,
    input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]       fwd_mem_data,
    input  logic                  fwd_wb_we,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]       fwd_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            alu_op,
    output logic [XLEN-1:0]       alu_input_a,
    output logic [XLEN-1:0]       alu_input_b,
    output logic [XLEN-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_rd_we,
    output logic [31:0]           stall_cycles
);

    logic [REG_ADDR_W-1:0] rs1_idx, rs2_idx;
    logic [1:0]            a_sel, b_sel;
    logic [XLEN-1:0]       rs1_val, rs2_val, a_mux, b_mux;
    logic                  capture, hold, refresh_a, refresh_b;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign hold     = out_valid && !out_ready && !flush;

    // MEM is younger than WB, so it wins a double match; x0 never forwards.
    always_comb begin
        rs1_val = in_rs1_data;
        if (in_rs1_addr == '0)
            rs1_val = '0;
        else if (fwd_mem_we && fwd_mem_rd == in_rs1_addr)
            rs1_val = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == in_rs1_addr)
            rs1_val = fwd_wb_data;

        rs2_val = in_rs2_data;
        if (in_rs2_addr == '0)
            rs2_val = '0;
        else if (fwd_mem_we && fwd_mem_rd == in_rs2_addr)
            rs2_val = fwd_mem_data;
        else if (fwd_wb_we && fwd_wb_rd == in_rs2_addr)
            rs2_val = fwd_wb_data;
    end

    always_comb begin
        case (in_a_sel)
            2'd1:    a_mux = in_pc;
            2'd2:    a_mux = '0;
            default: a_mux = rs1_val;
        endcase
        case (in_b_sel)
            2'd1:    b_mux = in_imm;
            2'd2:    b_mux = XLEN'(4);
            default: b_mux = rs2_val;
        endcase
    end

    // Only register-sourced operands may be overwritten by a WB that lands during a stall.
    assign refresh_a = hold && fwd_wb_we && (rs1_idx != '0) && (fwd_wb_rd == rs1_idx)
                       && (a_sel == 2'd0 || a_sel == 2'd3);
    assign refresh_b = hold && fwd_wb_we && (rs2_idx != '0) && (fwd_wb_rd == rs2_idx)
                       && (b_sel == 2'd0 || b_sel == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            alu_op       <= '0;
            alu_input_a  <= '0;
            alu_input_b  <= '0;
            out_pc       <= '0;
            out_rd_addr  <= '0;
            out_rd_we    <= 1'b0;
            stall_cycles <= '0;
            rs1_idx      <= '0;
            rs2_idx      <= '0;
            a_sel        <= '0;
            b_sel        <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
                out_rd_we <= 1'b0;
            end else if (capture) begin
                out_valid   <= 1'b1;
                alu_op      <= in_alu_op;
                alu_input_a <= a_mux;
                alu_input_b <= b_mux;
                out_pc      <= in_pc;
                out_rd_addr <= in_rd_addr;
                out_rd_we   <= in_rd_we;
                rs1_idx     <= in_rs1_addr;
                rs2_idx     <= in_rs2_addr;
                a_sel       <= in_a_sel;
                b_sel       <= in_b_sel;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else begin
                if (refresh_a)
                    alu_input_a <= fwd_wb_data;
                if (refresh_b)
                    alu_input_b <= fwd_wb_data;
            end
            if (hold)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-computed vectors checked with immediate assertions.
module tb_alu_issue_stage;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd4;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, in_rd_we;
    logic [XLEN-1:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [RW-1:0]   in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]      in_alu_op;
    logic [1:0]      in_a_sel, in_b_sel;
    logic            fwd_mem_we, fwd_wb_we;
    logic [RW-1:0]   fwd_mem_rd, fwd_wb_rd;
    logic [XLEN-1:0] fwd_mem_data, fwd_wb_data;
    logic            out_valid, out_ready, out_rd_we;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_input_a, alu_input_b, out_pc;
    logic [RW-1:0]   out_rd_addr;
    logic [31:0]     stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_alu_op(in_alu_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .alu_input_a(alu_input_a), .alu_input_b(alu_input_b), .out_pc(out_pc),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [RW-1:0] r1, input logic [31:0] d1,
                         input logic [RW-1:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [3:0] op, input logic [1:0] as, input logic [1:0] bs,
                         input logic [31:0] pc, input logic [RW-1:0] rd, input logic we);
        in_valid = v; in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
        in_imm = imm; in_alu_op = op; in_a_sel = as; in_b_sel = bs; in_pc = pc;
        in_rd_addr = rd; in_rd_we = we;
    endtask

    task automatic fwd(input logic mwe, input logic [RW-1:0] mrd, input logic [31:0] md,
                       input logic wwe, input logic [RW-1:0] wrd, input logic [31:0] wd);
        fwd_mem_we = mwe; fwd_mem_rd = mrd; fwd_mem_data = md;
        fwd_wb_we = wwe; fwd_wb_rd = wrd; fwd_wb_data = wd;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        fwd(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_a", alu_input_a, 0);
        reset = 1'b0;

        // basic issue
        drive(1, 1, 5, 2, 0, 7, OP_ADD, 0, 1, 32'h100, 5, 1);
        tick();
        chk("basic_valid", 32'(out_valid), 1);
        chk("basic_a", alu_input_a, 5);
        chk("basic_b", alu_input_b, 7);
        chk("basic_op", 32'(alu_op), 32'(OP_ADD));
        chk("basic_pc", out_pc, 32'h100);
        chk("basic_rd", 32'(out_rd_addr), 5);
        chk("basic_we", 32'(out_rd_we), 1);

        // MEM beats WB on a double match; b_sel=2 gives 4
        drive(1, 3, 32'h1111, 2, 0, 0, OP_SUB, 0, 2, 32'h104, 6, 0);
        fwd(1, 3, 32'hAAAA, 1, 3, 32'hBBBB);
        tick();
        chk("fwd_mem_a", alu_input_a, 32'hAAAA);
        chk("fwd_const4_b", alu_input_b, 4);
        chk("fwd_op", 32'(alu_op), 32'(OP_SUB));
        chk("fwd_we", 32'(out_rd_we), 0);

        // WB-only match on rs1 (a_sel=3), MEM match on rs2
        drive(1, 3, 32'h1111, 7, 32'h22, 0, OP_ADD, 3, 0, 32'h108, 1, 1);
        fwd(1, 7, 32'h7777, 1, 3, 32'hBBBB);
        tick();
        chk("fwd_wb_a", alu_input_a, 32'hBBBB);
        chk("fwd_mem_b", alu_input_b, 32'h7777);

        // x0 never forwards
        drive(1, 0, 32'h55, 0, 32'h66, 0, OP_ADD, 0, 3, 32'h10C, 1, 1);
        fwd(1, 0, 9, 1, 0, 10);
        tick();
        chk("x0_a", alu_input_a, 0);
        chk("x0_b", alu_input_b, 0);

        // PC as A source
        drive(1, 1, 32'h55, 0, 0, 0, OP_ADD, 1, 2, 32'h300, 1, 1);
        fwd(0, 0, 0, 0, 0, 0);
        tick();
        chk("pc_a", alu_input_a, 32'h300);
        chk("pc_out", out_pc, 32'h300);

        // drain without refill keeps data
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_a_hold", alu_input_a, 32'h300);

        // stall refresh, both operands on x4; MEM ignored during hold
        out_ready = 1'b0;
        drive(1, 4, 32'h10, 4, 32'h10, 0, OP_ADD, 0, 0, 32'h400, 2, 1);
        tick();
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_ready", 32'(in_ready), 0);
        chk("hold_a0", alu_input_a, 32'h10);
        drive(1, 4, 32'hEE, 4, 32'hEE, 0, OP_ADD, 0, 0, 32'h500, 2, 1);
        fwd(1, 4, 32'h9999, 1, 4, 32'h1234);
        tick();
        chk("refresh_a", alu_input_a, 32'h1234);
        chk("refresh_b", alu_input_b, 32'h1234);
        chk("refresh_pc", out_pc, 32'h400);
        chk("stall_1", stall_cycles, 1);
        fwd(0, 0, 0, 1, 5, 32'h5555);
        tick();
        chk("norefresh_a", alu_input_a, 32'h1234);
        chk("stall_2", stall_cycles, 2);

        // immediate operand is not refreshed
        out_ready = 1'b1;
        drive(1, 4, 32'h20, 4, 32'h30, 8, OP_ADD, 0, 1, 32'h600, 3, 1);
        fwd(0, 0, 0, 0, 0, 0);
        tick();
        chk("imm_b0", alu_input_b, 8);
        chk("stall_still2", stall_cycles, 2);
        in_valid = 1'b0; out_ready = 1'b0;
        fwd(0, 0, 0, 1, 4, 32'hCAFE);
        tick();
        chk("imm_refresh_a", alu_input_a, 32'hCAFE);
        chk("imm_b_kept", alu_input_b, 8);
        chk("stall_3", stall_cycles, 3);

        // flush while holding
        flush = 1'b1; in_valid = 1'b1;
        fwd(0, 0, 0, 1, 4, 32'hDEAD);
        tick();
        chk("flush_hold_valid", 32'(out_valid), 0);
        chk("flush_hold_we", 32'(out_rd_we), 0);
        chk("flush_hold_stall", stall_cycles, 3);
        chk("flush_hold_a", alu_input_a, 32'hCAFE);

        // flush with stage empty blocks capture
        out_ready = 1'b1;
        fwd(0, 0, 0, 0, 0, 0);
        tick();
        chk("flush_empty_valid", 32'(out_valid), 0);
        flush = 1'b0;

        // reset mid-stall
        out_ready = 1'b0;
        drive(1, 1, 32'h77, 2, 32'h88, 0, OP_XOR, 0, 0, 32'h700, 9, 1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("prereset_stall", stall_cycles, 6);
        chk("prereset_op", 32'(alu_op), 32'(OP_XOR));
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_op", 32'(alu_op), 0);
        chk("mid_rst_a", alu_input_a, 0);
        chk("mid_rst_b", alu_input_b, 0);
        chk("mid_rst_pc", out_pc, 0);
        chk("mid_rst_rd", 32'(out_rd_addr), 0);
        chk("mid_rst_we", 32'(out_rd_we), 0);
        chk("mid_rst_stall", stall_cycles, 0);
        tick();
        reset = 1'b0;

        // back-to-back throughput
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'(100 + i), 0, 0, 0, OP_ADD, 0, 2, 32'h800 + 32'(4 * i), 1, 1);
            tick();
            chk("b2b_valid", 32'(out_valid), 1);
            chk("b2b_ready", 32'(in_ready), 1);
            chk("b2b_a", alu_input_a, 32'(100 + i));
        end
        chk("b2b_stall", stall_cycles, 0);
        in_valid = 1'b0;
        tick();
        chk("b2b_drain", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
